prog_clk_div: RTL and testbench
===============================

Name: prog_clk_div

Overview:
- Parametrised, runtime-programmable successor to the fixed 50 Hz divider used in the UART calculator.
- Produces a 50%-duty divided clock `clk_div` plus single-cycle rise/fall tick enables for downstream logic in the `clk` domain.
- The divisor is reloadable at run time through a shadow register. A new value takes effect only at a full-period boundary, so no runt pulses are produced.
- Sits between the board clock and the UART/display timing blocks.

Parameters:
- WIDTH, 25, width of counter, divisor and shadow registers.
- DEFAULT_DIV, 12500, half-period in `clk` cycles loaded at reset; must be ≥ 1 and < 2^WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  count enable; when low, the counter and `clk_div` hold.
- div_val  in  WIDTH  requested half-period in `clk` cycles.
- div_load  in  1  one-cycle strobe; captures `div_val`.
- clk_div  out  1  divided clock, period 2*hp cycles, 50% duty.
- tick_rise  out  1  one-cycle pulse in the cycle `clk_div` goes 0→1.
- tick_fall  out  1  one-cycle pulse in the cycle `clk_div` goes 1→0.
- pending  out  1  a captured divisor is waiting to be applied.
- load_err  out  1  one-cycle pulse: `div_load` was issued with `div_val`=0.

Behaviour:
- Reset (asynchronous):
  - cnt=0, hp=DEFAULT_DIV, shadow=DEFAULT_DIV.
  - clk_div=0, tick_rise=0, tick_fall=0, pending=0, load_err=0.
- All outputs are registered.
- Counting, en=1:
  - If cnt==hp-1: cnt←0, clk_div←~clk_div. In that same clock edge, tick_rise←(clk_div==0) and tick_fall←(clk_div==1).
  - Otherwise: cnt←cnt+1, ticks←0.
  - Boundary cases: hp=1 gives clk/2; ticks alternate rise/fall every cycle.
- en=0: cnt and clk_div hold; both ticks are 0.
- Load capture, div_load=1:
  - div_val=0: load_err pulses next cycle; shadow and pending are unchanged.
  - div_val≠0: shadow←div_val, pending←1. A later load before apply overwrites shadow (last write wins).
- Apply, pending=1 and en=1:
  - Applied at the full-period boundary only, i.e. the wrap cycle where clk_div goes 1→0.
  - In that cycle: hp←shadow, cnt←0, pending←0.
  - The first new half-period starts with clk_div=0.
- Apply, pending=1 and en=0: hp←shadow, cnt←0, clk_div←0, pending←0 in the next cycle. No tick is generated.
- Simultaneous valid div_load and apply boundary: the incoming div_val is applied directly (hp←div_val) and pending stays 0.
- Simultaneous div_load with div_val=0 and apply boundary: the existing shadow is applied; load_err pulses.
- cnt never exceeds hp-1, because hp changes only when cnt is reset to 0.
- Counter arithmetic is unsigned WIDTH bits with no overflow path.
- Reset mid-period or with pending=1 discards the shadow and returns to the reset values.

Optional Feature:
- Macro: SYNC_CLR_EN.
- Defined:
  - Adds input port `sync_clr` (1 bit).
  - When high: cnt←0, clk_div←0, ticks←0. This has priority over counting and over the en=0 apply.
  - pending and shadow are retained; a pending value is applied at the first full-period boundary after `sync_clr` deasserts.
  - Used to phase-align the divider to a UART start-bit detection.
- Undefined: the port does not exist and the behaviour is exactly as above.

Decomposition:
- Shared package `clk_div_pkg` holds:
  - DIV_WIDTH_DEFAULT=25
  - Named half-period constants DIV_50HZ_HALF=12500 and DIV_1KHZ_HALF=625 (for the 1.25 MHz timing base)
  - A function checking that a divisor is legal (nonzero, fits WIDTH)
- Single module; no sub-module is required. The shadow/pending logic stays inline because it shares the wrap condition with the counter.

Test Plan:
- Reset and default (DEFAULT_DIV=4, en=1, run 24 cycles):
  - clk_div=0 immediately after reset.
  - clk_div toggles every 4 cycles (period 8).
  - tick_rise at cycles 4, 12, 20; tick_fall at cycles 8, 16, 24.
- Mid-period reload:
  - Stimulus: div_load with div_val=2 at cycle 5, during the high phase.
  - pending=1 from cycle 6.
  - Old hp=4 completes to the fall at cycle 8; pending=0 there.
  - Afterwards period=4 cycles; no short pulse.
- Illegal and overwrite loads:
  - div_val=0: load_err one pulse; hp and pending unchanged.
  - Loads of 3 then 6 before the boundary: hp=6 after the boundary.
- Enable gating:
  - en=0 for 10 cycles mid-half-period: cnt and clk_div frozen, no ticks; counting resumes from the held cnt.
  - div_load 5 while en=0: hp=5, cnt=0, clk_div=0 one cycle later.
- Edge cases:
  - DEFAULT_DIV=1: clk_div=clk/2, ticks every cycle.
  - div_load on the exact boundary cycle: new value applied directly, pending stays 0.
  - Async rst pulse between clk edges with pending=1: all outputs return to reset values immediately, pending=0.
- With SYNC_CLR_EN defined:
  - sync_clr asserted 3 cycles mid-high-phase: clk_div=0 and cnt=0 during assertion, no ticks; the next rise comes hp cycles after deassertion.
  - A pending load is held during the clear and applied at the first subsequent fall.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Half-period values are in system-clock cycles.
package clk_div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 25;
  localparam int DIV_50HZ_HALF     = 12500;
  localparam int DIV_1KHZ_HALF     = 625;

  // A divisor is usable when it is nonzero and fits in w bits.
  function automatic logic div_legal(
    input logic [63:0] v,
    input int          w
  );
    logic fits;
    fits = (w >= 64) ? 1'b1 : ((v >> w) == 64'd0);
    return (v != 64'd0) && fits;
  endfunction

endpackage

// File: rtl/prog_clk_div.sv
// Runtime-programmable 50% duty clock divider with rise/fall ticks.
// Optional macro SYNC_CLR_EN adds a synchronous phase-clear input.
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = DIV_WIDTH_DEFAULT,
  parameter int DEFAULT_DIV = DIV_50HZ_HALF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SYNC_CLR_EN
  input  logic             sync_clr,
`endif
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             clk_div,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             pending,
  output logic             load_err
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hp;
  logic [WIDTH-1:0] shadow;

  logic [WIDTH-1:0] cnt_n;
  logic [WIDTH-1:0] hp_n;
  logic [WIDTH-1:0] shadow_n;
  logic             pending_n;
  logic             clk_div_n;
  logic             rise_n;
  logic             fall_n;

  logic             clr;
  logic             ld_ok;
  logic             ld_bad;
  logic             wrap;

`ifdef SYNC_CLR_EN
  assign clr = sync_clr;
`else
  assign clr = 1'b0;
`endif

  assign ld_ok  = div_load & div_legal(64'(div_val), WIDTH);
  assign ld_bad = div_load & ~ld_ok;
  assign wrap   = (cnt == hp - WIDTH'(1));

  // Next-state: counter, divided clock, ticks and divisor hand-over.
  always_comb begin
    cnt_n     = cnt;
    hp_n      = hp;
    shadow_n  = shadow;
    pending_n = pending;
    clk_div_n = clk_div;
    rise_n    = 1'b0;
    fall_n    = 1'b0;

    if (ld_ok) begin
      shadow_n  = div_val;
      pending_n = 1'b1;
    end

    if (clr) begin
      cnt_n     = '0;
      clk_div_n = 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt_n     = '0;
        clk_div_n = ~clk_div;
        rise_n    = ~clk_div;
        fall_n    = clk_div;
        // Falling wrap closes a full period: safe point to swap hp.
        // A valid load arriving right here bypasses the shadow.
        if (clk_div) begin
          if (ld_ok) begin
            hp_n      = div_val;
            pending_n = 1'b0;
          end else if (pending) begin
            hp_n      = shadow;
            pending_n = 1'b0;
          end
        end
      end else begin
        cnt_n = cnt + WIDTH'(1);
      end
    end else if (pending) begin
      // Stopped divider: no period to protect, restart from low phase.
      hp_n      = ld_ok ? div_val : shadow;
      cnt_n     = '0;
      clk_div_n = 1'b0;
      pending_n = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      hp        <= WIDTH'(DEFAULT_DIV);
      shadow    <= WIDTH'(DEFAULT_DIV);
      pending   <= 1'b0;
      clk_div   <= 1'b0;
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      hp        <= hp_n;
      shadow    <= shadow_n;
      pending   <= pending_n;
      clk_div   <= clk_div_n;
      tick_rise <= rise_n;
      tick_fall <= fall_n;
      load_err  <= ld_bad;
    end
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed table-driven bench for prog_clk_div.
// Main instance uses hp=4, a second instance checks hp=1.
module tb_prog_clk_div;

  typedef struct {
    logic       en;
    logic       ld;
    logic [7:0] val;
    logic       clr;
    logic [4:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div_val = 8'd0;
  logic       div_load = 1'b0;
  logic       clk_div, tick_rise, tick_fall, pending, load_err;
`ifdef SYNC_CLR_EN
  logic       sync_clr = 1'b0;
`endif

  logic       en1 = 1'b0;
  logic [7:0] div_val1 = 8'd0;
  logic       div_load1 = 1'b0;
  logic       clk_div1, tick_rise1, tick_fall1, pending1, load_err1;
`ifdef SYNC_CLR_EN
  logic       sync_clr1 = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  vec_t q[$];

  always #5 clk = ~clk;

  prog_clk_div #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef SYNC_CLR_EN
    .sync_clr(sync_clr),
`endif
    .en(en),
    .div_val(div_val),
    .div_load(div_load),
    .clk_div(clk_div),
    .tick_rise(tick_rise),
    .tick_fall(tick_fall),
    .pending(pending),
    .load_err(load_err)
  );

  prog_clk_div #(.WIDTH(8), .DEFAULT_DIV(1)) dut1 (
    .clk(clk),
    .rst(rst),
`ifdef SYNC_CLR_EN
    .sync_clr(sync_clr1),
`endif
    .en(en1),
    .div_val(div_val1),
    .div_load(div_load1),
    .clk_div(clk_div1),
    .tick_rise(tick_rise1),
    .tick_fall(tick_fall1),
    .pending(pending1),
    .load_err(load_err1)
  );

  function automatic logic [4:0] outs();
    return {clk_div, tick_rise, tick_fall, pending, load_err};
  endfunction

  task automatic check(string name, int row, logic [4:0] got,
                       logic [4:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s row %0d: ck/r/f/p/e got %b want %b",
               name, row, got, want);
    end
  endtask

  task automatic add(logic e, logic ld, logic [7:0] v,
                     logic ck, logic r, logic f, logic p, logic er,
                     logic c = 1'b0);
    vec_t t;
    t.en = e;
    t.ld = ld;
    t.val = v;
    t.clr = c;
    t.exp = {ck, r, f, p, er};
    q.push_back(t);
  endtask

  task automatic hold(int n, logic ck, logic p);
    for (int i = 0; i < n; i++) add(1, 0, 0, ck, 0, 0, p, 0);
  endtask

  task automatic rise(logic p);
    add(1, 0, 0, 1, 1, 0, p, 0);
  endtask

  task automatic fall(logic p);
    add(1, 0, 0, 0, 0, 1, p, 0);
  endtask

  // Async reset between clock edges; outputs must clear at once.
  task automatic do_reset(string name);
    #2;
    en = 1'b0;
    div_load = 1'b0;
    div_val = 8'd0;
`ifdef SYNC_CLR_EN
    sync_clr = 1'b0;
`endif
    rst = 1'b1;
    #1;
    check(name, 0, outs(), 5'b00000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(string name);
    for (int i = 0; i < q.size(); i++) begin
      en = q[i].en;
      div_load = q[i].ld;
      div_val = q[i].val;
`ifdef SYNC_CLR_EN
      sync_clr = q[i].clr;
`endif
      @(posedge clk);
      #1;
      check(name, i + 1, outs(), q[i].exp);
    end
    en = 1'b0;
    div_load = 1'b0;
    div_val = 8'd0;
    q.delete();
  endtask

  initial begin
    // Default divisor: rises at 4,12,20, falls at 8,16,24.
    do_reset("rst_default");
    for (int k = 0; k < 3; k++) begin
      hold(3, 0, 0);
      rise(0);
      hold(3, 1, 0);
      fall(0);
    end
    run("default");

    // Reload of 2 during high phase, applied at the fall.
    do_reset("rst_reload");
    hold(3, 0, 0);
    rise(0);
    hold(1, 1, 0);
    add(1, 1, 2, 1, 0, 0, 1, 0);
    hold(1, 1, 1);
    fall(0);
    for (int k = 0; k < 2; k++) begin
      hold(1, 0, 0);
      rise(0);
      hold(1, 1, 0);
      fall(0);
    end
    run("reload");

    // Zero load, then 3 overwritten by 6 before the boundary.
    do_reset("rst_overwrite");
    add(1, 1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 3, 0, 0, 0, 1, 0);
    add(1, 1, 6, 0, 0, 0, 1, 0);
    rise(1);
    add(1, 1, 0, 1, 0, 0, 1, 1);
    hold(2, 1, 1);
    fall(0);
    hold(5, 0, 0);
    rise(0);
    hold(5, 1, 0);
    fall(0);
    run("overwrite");

    // Enable gating, then a load while stopped.
    do_reset("rst_enable");
    hold(2, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 0, 0);
    hold(1, 0, 0);
    rise(0);
    hold(1, 1, 0);
    add(0, 1, 5, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    hold(4, 0, 0);
    rise(0);
    hold(4, 1, 0);
    fall(0);
    run("enable");

    // Loads landing exactly on the falling boundary.
    do_reset("rst_boundary");
    hold(3, 0, 0);
    rise(0);
    hold(3, 1, 0);
    add(1, 1, 2, 0, 0, 1, 0, 0);
    hold(1, 0, 0);
    rise(0);
    hold(1, 1, 0);
    fall(0);
    add(1, 1, 3, 0, 0, 0, 1, 0);
    rise(1);
    hold(1, 1, 1);
    add(1, 1, 0, 0, 0, 1, 0, 1);
    hold(2, 0, 0);
    rise(0);
    run("boundary");

    // Async reset with a pending load discards the shadow.
    do_reset("rst_async_a");
    hold(3, 0, 0);
    rise(0);
    add(1, 1, 7, 1, 0, 0, 1, 0);
    hold(1, 1, 1);
    run("pre_async");
    do_reset("rst_async_b");
    hold(3, 0, 0);
    rise(0);
    hold(3, 1, 0);
    fall(0);
    hold(3, 0, 0);
    rise(0);
    run("post_async");

`ifdef SYNC_CLR_EN
    // Phase clear in high phase with a pending load held across it.
    do_reset("rst_sync_clr");
    hold(3, 0, 0);
    rise(0);
    add(1, 1, 2, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 1, 0, 1);
    hold(3, 0, 1);
    rise(1);
    hold(3, 1, 1);
    fall(0);
    hold(1, 0, 0);
    rise(0);
    run("sync_clr");
`endif

    // hp=1 instance: clk/2 with alternating ticks.
    en1 = 1'b1;
    do_reset("rst_div1");
    for (int k = 1; k <= 6; k++) begin
      logic [2:0] want;
      want = (k % 2 == 1) ? 3'b110 : 3'b001;
      @(posedge clk);
      #1;
      check("div1", k, {2'b00, clk_div1, tick_rise1, tick_fall1},
            {2'b00, want});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
